// File: rtl/udp_head_rx_if.sv
// Stream bundle between the IPv4 receive path, the UDP header parser and the application.
// Latency: none (wires only).
// Backpressure: none; the source streams one beat per cycle whenever valid_i is high.
interface udp_head_rx_if #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = DATA_W / 8,
    parameter int PORT_W = 16,
    parameter int LEN_W  = 16,
    parameter int CRC_W  = 16
);
    // segment stream from the IPv4 receive path
    logic              valid_i;
    logic              start_i;
    logic [DATA_W-1:0] data_i;
    logic [KEEP_W-1:0] keep_i;
    logic              last_i;
    // parsed header
    logic              head_v_o;
    logic [PORT_W-1:0] src_port_o;
    logic [PORT_W-1:0] dst_port_o;
    logic [LEN_W-1:0]  len_o;
    logic [CRC_W-1:0]  crc_o;
    logic              port_match_o;
    // payload stream to the application
    logic              data_v_o;
    logic [DATA_W-1:0] data_o;
    logic [KEEP_W-1:0] keep_o;
    logic              data_last_o;
    logic              err_o;

    modport master (
        output valid_i, start_i, data_i, keep_i, last_i,
        input  head_v_o, src_port_o, dst_port_o, len_o, crc_o, port_match_o,
        input  data_v_o, data_o, keep_o, data_last_o, err_o
    );

    modport slave (
        input  valid_i, start_i, data_i, keep_i, last_i,
        output head_v_o, src_port_o, dst_port_o, len_o, crc_o, port_match_o,
        output data_v_o, data_o, keep_o, data_last_o, err_o
    );
endinterface

// File: rtl/udp_head_rx.sv
// UDP receive header parser: extracts src/dst/len/crc, strips header and padding, forwards payload.
// Latency: 1 cycle from input beat to registered output (header on beat3, payload per beat).
// Backpressure: none; accepts one beat per cycle, back-to-back segments allowed.
module udp_head_rx #(
    parameter int DATA_W   = 16,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int PORT_W   = 16,
    parameter int LEN_W    = 16,
    parameter int CRC_W    = 16,
    parameter logic [PORT_W-1:0] DST_PORT = 16'd18170
) (
    input logic         clk,
    input logic         nreset,
    udp_head_rx_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    // UDP length counts the 8 header bytes; the extra bit catches lengths below 8.
    localparam logic [LEN_W:0] HDR_LEN = (LEN_W + 1)'(8);

    logic [1:0]        state_q, state_d;
    logic [1:0]        hcnt_q, hcnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [PORT_W-1:0] sp_q, sp_d;       // src port staged until beat3
    logic [PORT_W-1:0] dp_q, dp_d;       // dst port staged until beat3
    logic [LEN_W-1:0]  ul_q, ul_d;       // raw UDP length staged until beat3
    logic              head_v_q, head_v_d;
    logic [PORT_W-1:0] src_q, src_d;
    logic [PORT_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic              pm_q, pm_d;
    logic              dv_q, dv_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              dlast_q, dlast_d;
    logic              err_q, err_d;

    logic [LEN_W-1:0]  nb;
    logic [KEEP_W-1:0] keep_trim;
    logic [LEN_W:0]    pay_len;
    logic              len_borrow;
    logic              dst_hit;

    // Byte count of the current beat, and its keep clipped to the bytes still owed.
    always_comb begin
        nb        = '0;
        keep_trim = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            nb           = nb + LEN_W'(bus.keep_i[i]);
            keep_trim[i] = bus.keep_i[i] & (rem_q > LEN_W'(i));
        end
    end

    assign pay_len    = {1'b0, ul_q} - HDR_LEN;
    assign len_borrow = pay_len[LEN_W];
    assign dst_hit    = (dp_q == DST_PORT);

    // Segment state machine plus next values of every registered output.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        rem_d    = rem_q;
        sp_d     = sp_q;
        dp_d     = dp_q;
        ul_d     = ul_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        crc_d    = crc_q;
        pm_d     = pm_q;
        head_v_d = 1'b0;
        dv_d     = 1'b0;
        dat_d    = '0;
        keep_d   = '0;
        dlast_d  = 1'b0;
        err_d    = 1'b0;
        if (bus.valid_i) begin
            if (bus.start_i) begin
                // a new segment always wins; an unfinished one is abandoned silently on the data side
                if (state_q == S_HEAD || state_q == S_PAY) err_d = 1'b1;
                if (bus.last_i) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HEAD;
                    hcnt_d  = 2'd1;
                    sp_d    = PORT_W'(bus.data_i);
                end
            end else begin
                case (state_q)
                    S_HEAD: begin
                        if (hcnt_q != 2'd3) begin
                            if (hcnt_q == 2'd1) dp_d = PORT_W'(bus.data_i);
                            else                ul_d = LEN_W'(bus.data_i);
                            hcnt_d = hcnt_q + 2'd1;
                            if (bus.last_i) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            hcnt_d   = 2'd0;
                            head_v_d = 1'b1;
                            src_d    = sp_q;
                            dst_d    = dp_q;
                            crc_d    = CRC_W'(bus.data_i);
                            len_d    = pay_len[LEN_W-1:0];
                            pm_d     = dst_hit;
                            if (len_borrow) begin
                                err_d   = 1'b1;
                                state_d = bus.last_i ? S_IDLE : S_DROP;
                            end else if (bus.last_i && pay_len[LEN_W-1:0] != '0) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else if (pay_len[LEN_W-1:0] == '0 || !dst_hit) begin
                                state_d = bus.last_i ? S_IDLE : S_DROP;
                            end else begin
                                state_d = S_PAY;
                                rem_d   = pay_len[LEN_W-1:0];
                            end
                        end
                    end
                    S_PAY: begin
                        dv_d  = 1'b1;
                        dat_d = bus.data_i;
                        if (rem_q <= nb) begin
                            // final payload beat; anything after it is Ethernet padding
                            keep_d  = keep_trim;
                            dlast_d = 1'b1;
                            rem_d   = '0;
                            state_d = bus.last_i ? S_IDLE : S_DROP;
                        end else if (bus.last_i) begin
                            keep_d  = bus.keep_i;
                            dlast_d = 1'b1;
                            err_d   = 1'b1;
                            rem_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            keep_d = bus.keep_i;
                            rem_d  = rem_q - nb;
                        end
                    end
                    S_DROP: begin
                        if (bus.last_i) state_d = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and output registers; reset discards any segment in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            hcnt_q   <= '0;
            rem_q    <= '0;
            sp_q     <= '0;
            dp_q     <= '0;
            ul_q     <= '0;
            head_v_q <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            crc_q    <= '0;
            pm_q     <= 1'b0;
            dv_q     <= 1'b0;
            dat_q    <= '0;
            keep_q   <= '0;
            dlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            rem_q    <= rem_d;
            sp_q     <= sp_d;
            dp_q     <= dp_d;
            ul_q     <= ul_d;
            head_v_q <= head_v_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            pm_q     <= pm_d;
            dv_q     <= dv_d;
            dat_q    <= dat_d;
            keep_q   <= keep_d;
            dlast_q  <= dlast_d;
            err_q    <= err_d;
        end
    end

    assign bus.head_v_o     = head_v_q;
    assign bus.src_port_o   = src_q;
    assign bus.dst_port_o   = dst_q;
    assign bus.len_o        = len_q;
    assign bus.crc_o        = crc_q;
    assign bus.port_match_o = pm_q;
    assign bus.data_v_o     = dv_q;
    assign bus.data_o       = dat_q;
    assign bus.keep_o       = keep_q;
    assign bus.data_last_o  = dlast_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_udp_head_rx.sv
// Self-checking bench for udp_head_rx: per-beat vector table with expected outputs.
// Latency: expectations are compared 1 cycle after each beat is driven.
// Backpressure: none; the bench streams one beat per cycle.
module tb_udp_head_rx;
    localparam logic [15:0] P = 16'd18170;

    logic clk;
    logic nreset;
    udp_head_rx_if bus ();

    udp_head_rx dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
        logic        hv;
        logic        pm;
        logic [15:0] len;
        logic        dv;
        logic [1:0]  dk;
        logic        dl;
        logic        er;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic s, logic [15:0] d, logic [1:0] k, logic l,
                                logic hv, logic pm, logic [15:0] len,
                                logic dv, logic [1:0] dk, logic dl, logic er);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.k = k; t.l = l;
        t.hv = hv; t.pm = pm; t.len = len;
        t.dv = dv; t.dk = dk; t.dl = dl; t.er = er;
        return t;
    endfunction

    // input beat with no output expected
    function automatic vec_t nx(logic s, logic [15:0] d, logic l);
        return mk(1'b1, s, d, 2'b11, l, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction
    // checksum beat: header pulse expected
    function automatic vec_t hd(logic [15:0] d, logic l, logic pm, logic [15:0] len, logic er);
        return mk(1'b1, 1'b0, d, 2'b11, l, 1'b1, pm, len, 1'b0, 2'b00, 1'b0, er);
    endfunction
    // payload beat: forwarded data expected
    function automatic vec_t py(logic [15:0] d, logic [1:0] k, logic l, logic [1:0] dk, logic dl, logic er);
        return mk(1'b1, 1'b0, d, k, l, 1'b0, 1'b0, 16'd0, 1'b1, dk, dl, er);
    endfunction
    // beat whose only effect is an error pulse
    function automatic vec_t eb(logic s, logic [15:0] d, logic l);
        return mk(1'b1, s, d, 2'b11, l, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 1'b0, 1'b1);
    endfunction
    function automatic vec_t gap();
        return mk(1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction

    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk);
        bus.valid_i = t.v;
        bus.start_i = t.s;
        bus.data_i  = t.d;
        bus.keep_i  = t.k;
        bus.last_i  = t.l;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("head_v", 16'(bus.head_v_o), 16'(e.hv));
        chk("err", 16'(bus.err_o), 16'(e.er));
        chk("data_v", 16'(bus.data_v_o), 16'(e.dv));
        if (e.hv) begin
            chk("port_match", 16'(bus.port_match_o), 16'(e.pm));
            chk("len", bus.len_o, e.len);
            chk("crc", bus.crc_o, e.d);
        end
        if (e.dv) begin
            chk("data", bus.data_o, e.d);
            chk("keep", 16'(bus.keep_o), 16'(e.dk));
            chk("data_last", 16'(bus.data_last_o), 16'(e.dl));
        end else begin
            chk("data_idle", bus.data_o, 16'h0);
        end
    endtask

    function automatic logic any_out();
        return |{bus.head_v_o, bus.src_port_o, bus.dst_port_o, bus.len_o, bus.crc_o,
                 bus.port_match_o, bus.data_v_o, bus.data_o, bus.keep_o, bus.data_last_o, bus.err_o};
    endfunction

    initial begin
        nreset      = 1'b0;
        bus.valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        bus.keep_i  = '0;
        bus.last_i  = 1'b0;

        // basic segment: 2 payload beats then 2 padding beats
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd12, 0));
        tbl.push_back(hd(16'h0000, 0, 1, 16'd4, 0));
        tbl.push_back(py(16'hA1B2, 2'b11, 0, 2'b11, 0, 0));
        tbl.push_back(py(16'hC3D4, 2'b11, 0, 2'b11, 1, 0));
        tbl.push_back(nx(0, 16'h0, 0));
        tbl.push_back(nx(0, 16'h0, 1));
        // odd length: last beat trimmed to one byte
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd13, 0));
        tbl.push_back(hd(16'hBEEF, 0, 1, 16'd5, 0));
        tbl.push_back(py(16'h1111, 2'b11, 0, 2'b11, 0, 0));
        tbl.push_back(py(16'h2222, 2'b11, 0, 2'b11, 0, 0));
        tbl.push_back(py(16'h3333, 2'b11, 1, 2'b01, 1, 0));
        // foreign destination port: header only, payload dropped
        tbl.push_back(nx(1, 16'h0400, 0));
        tbl.push_back(nx(0, 16'h1234, 0));
        tbl.push_back(nx(0, 16'd10, 0));
        tbl.push_back(hd(16'h0000, 0, 0, 16'd2, 0));
        tbl.push_back(nx(0, 16'hDEAD, 1));
        tbl.push_back(gap());
        // length below 8: wrapped len and error
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd6, 0));
        tbl.push_back(hd(16'h0000, 0, 1, 16'hFFFE, 1));
        tbl.push_back(nx(0, 16'h5555, 1));
        // last on the length beat
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(eb(0, 16'd12, 1));
        // start during payload aborts, then new header with a one-byte beat
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd12, 0));
        tbl.push_back(hd(16'h0000, 0, 1, 16'd4, 0));
        tbl.push_back(py(16'hAAAA, 2'b11, 0, 2'b11, 0, 0));
        tbl.push_back(eb(1, 16'h0001, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd10, 0));
        tbl.push_back(hd(16'h0000, 0, 1, 16'd2, 0));
        tbl.push_back(py(16'hBB00, 2'b01, 0, 2'b01, 0, 0));
        tbl.push_back(py(16'hCC11, 2'b11, 1, 2'b01, 1, 0));
        // truncated payload: data_last and err together
        tbl.push_back(nx(1, P, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(nx(0, 16'd14, 0));
        tbl.push_back(hd(16'h0000, 0, 1, 16'd6, 0));
        tbl.push_back(py(16'h1234, 2'b11, 0, 2'b11, 0, 0));
        tbl.push_back(py(16'h5678, 2'b11, 1, 2'b11, 1, 1));
        // start and last together in idle
        tbl.push_back(eb(1, 16'h0000, 1));
        // empty payload ending on the checksum beat, with an idle gap inside the header
        tbl.push_back(nx(1, 16'h0042, 0));
        tbl.push_back(nx(0, P, 0));
        tbl.push_back(gap());
        tbl.push_back(nx(0, 16'd8, 0));
        tbl.push_back(hd(16'h5A5A, 1, 1, 16'd0, 0));
        tbl.push_back(gap());

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 16'(any_out()), 16'd0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // header fields hold after the last header
        chk("hold_src", bus.src_port_o, 16'h0042);
        chk("hold_dst", bus.dst_port_o, P);
        chk("hold_crc", bus.crc_o, 16'h5A5A);

        // reset in the middle of a payload
        apply(nx(1, P, 0));
        apply(nx(0, P, 0));
        apply(nx(0, 16'd12, 0));
        apply(hd(16'h0000, 0, 1, 16'd4, 0));
        apply(py(16'h7777, 2'b11, 0, 2'b11, 0, 0));
        nreset = 1'b0;
        #1;
        chk("rst_mid_outputs", 16'(any_out()), 16'd0);
        @(negedge clk);
        nreset = 1'b1;
        apply(nx(1, P, 0));
        apply(nx(0, P, 0));
        apply(nx(0, 16'd10, 0));
        apply(hd(16'h0101, 0, 1, 16'd2, 0));
        apply(py(16'h9999, 2'b11, 1, 2'b11, 1, 0));
        apply(gap());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
